// File: rtl/mem_ctrl_if.sv
// Cache <-> memory-controller bus. The cache drives the *_IN side and the
// controller drives the *_OUT side.
interface mem_ctrl_if #(
  parameter int ADDR2_BUS_SIZE = 6,
  parameter int DATA2_BUS_SIZE = 16
);
  logic [1:0]                C2_IN;
  logic [ADDR2_BUS_SIZE-1:0] A2_IN;
  logic [DATA2_BUS_SIZE-1:0] D2_IN;
  logic [1:0]                C2_OUT;
  logic                      C2_OE;
  logic [DATA2_BUS_SIZE-1:0] D2_OUT;
  logic                      D2_OE;
  logic                      BUSY;

  modport master (
    output C2_IN, A2_IN, D2_IN,
    input  C2_OUT, C2_OE, D2_OUT, D2_OE, BUSY
  );

  modport slave (
    input  C2_IN, A2_IN, D2_IN,
    output C2_OUT, C2_OE, D2_OUT, D2_OE, BUSY
  );
endinterface

// File: rtl/mem_ctrl.sv
// Line-oriented memory controller: accepts one READ_LINE/WRITE_LINE at a time,
// waits MEM_LATENCY cycles, then answers with registered RESPONSE beats.
module mem_ctrl #(
  parameter int ADDR2_BUS_SIZE  = 6,
  parameter int DATA2_BUS_SIZE  = 16,
  parameter int CACHE_LINE_SIZE = 16,
  parameter int MEM_LATENCY     = 4
) (
  input  logic      CLK,
  input  logic      RESET_N,
  mem_ctrl_if.slave bus
);
  localparam int NB        = CACHE_LINE_SIZE * 8 / DATA2_BUS_SIZE;
  localparam int LINE_BITS = CACHE_LINE_SIZE * 8;
  localparam int NLINES    = 2 ** ADDR2_BUS_SIZE;
  localparam int MEM_BITS  = NLINES * LINE_BITS;
  localparam int BW        = $clog2(NB + 1);

  localparam logic [7:0]    LAT_M1    = 8'(MEM_LATENCY - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);
  localparam logic [BW-1:0] BEAT_END  = BW'(NB);

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_RESP  = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_WRITE = 2'd3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RECV_WR = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RESP_RD = 3'd3;
  localparam logic [2:0] S_RESP_WR = 3'd4;

  // Power-up image: the byte at flat address a holds a mod 256.
  function automatic logic [MEM_BITS-1:0] f_power_up();
    logic [MEM_BITS-1:0] v;
    for (int a = 0; a < MEM_BITS / 8; a++) v[a*8 +: 8] = 8'(a);
    return v;
  endfunction

  // Flat little-endian storage: beat k of line n sits at beat slot n*NB+k.
  logic [MEM_BITS-1:0] r_mem = f_power_up();

  logic [2:0]                r_state;
  logic [7:0]                r_cnt;
  logic [BW-1:0]             r_beat;
  logic                      r_is_wr;
  logic [ADDR2_BUS_SIZE-1:0] r_addr;
  logic [LINE_BITS-1:0]      r_line;
  logic [1:0]                r_c2_out;
  logic                      r_c2_oe;
  logic [DATA2_BUS_SIZE-1:0] r_d2_out;
  logic                      r_d2_oe;

  logic [LINE_BITS-1:0]      w_line;
  logic [ADDR2_BUS_SIZE-1:0] w_wr_addr;
  logic                      w_commit;
  logic [DATA2_BUS_SIZE-1:0] w_rd_beat;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_line    = r_line;
    w_line[int'(r_beat)*DATA2_BUS_SIZE +: DATA2_BUS_SIZE] = bus.D2_IN;
    w_wr_addr = (r_state == S_IDLE) ? bus.A2_IN : r_addr;
    w_commit  = 1'b0;
    if (r_state == S_RECV_WR && r_beat == LAST_BEAT) w_commit = 1'b1;
    if (NB == 1 && r_state == S_IDLE && bus.C2_IN == CMD_WRITE) w_commit = 1'b1;
  end

  assign w_rd_beat = r_mem[(int'(r_addr)*NB + int'(r_beat))*DATA2_BUS_SIZE +: DATA2_BUS_SIZE];

  // NOTE: storage has no reset on purpose; a reset must never disturb committed lines.
  always_ff @(posedge CLK) begin
    if (w_commit) r_mem[int'(w_wr_addr)*LINE_BITS +: LINE_BITS] <= w_line;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_beat   <= '0;
      r_is_wr  <= 1'b0;
      r_addr   <= '0;
      r_line   <= '0;
      r_c2_out <= CMD_NOP;
      r_c2_oe  <= 1'b0;
      r_d2_out <= '0;
      r_d2_oe  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.C2_IN == CMD_READ) begin
            r_addr  <= bus.A2_IN;
            r_is_wr <= 1'b0;
            r_cnt   <= LAT_M1;
            r_state <= S_WAIT;
          end else if (bus.C2_IN == CMD_WRITE) begin
            r_addr  <= bus.A2_IN;
            r_is_wr <= 1'b1;
            r_line  <= w_line;
            if (NB == 1) begin
              r_cnt   <= LAT_M1;
              r_state <= S_WAIT;
            end else begin
              r_beat  <= r_beat + 1'b1;
              r_state <= S_RECV_WR;
            end
          end
        end
        S_RECV_WR: begin
          r_line <= w_line;
          if (r_beat == LAST_BEAT) begin
            r_beat  <= '0;
            r_cnt   <= LAT_M1;
            r_state <= S_WAIT;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_c2_out <= CMD_RESP;
            r_c2_oe  <= 1'b1;
            if (r_is_wr) begin
              r_state <= S_RESP_WR;
            end else begin
              r_d2_out <= w_rd_beat;
              r_d2_oe  <= 1'b1;
              r_beat   <= r_beat + 1'b1;
              r_state  <= S_RESP_RD;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_RESP_RD: begin
          if (r_beat == BEAT_END) begin
            r_beat   <= '0;
            r_c2_out <= CMD_NOP;
            r_c2_oe  <= 1'b0;
            r_d2_out <= '0;
            r_d2_oe  <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_d2_out <= w_rd_beat;
            r_beat   <= r_beat + 1'b1;
          end
        end
        S_RESP_WR: begin
          r_c2_out <= CMD_NOP;
          r_c2_oe  <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.C2_OUT = r_c2_out;
  assign bus.C2_OE  = r_c2_oe;
  assign bus.D2_OUT = r_d2_out;
  assign bus.D2_OE  = r_d2_oe;
  assign bus.BUSY   = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: two instances (latency 4 and latency 1), a
// byte-array reference memory per instance, and a negedge monitor per instance.
module tb_mem_ctrl;
  localparam int LAT0  = 4;
  localparam int LAT1  = 1;
  localparam int NB    = 8;
  localparam int LINES = 64;
  localparam logic [1:0] NOP = 2'd0, RESP = 2'd1, RD = 2'd2, WR = 2'd3;

  typedef struct {
    int          at;
    logic [1:0]  cmd;
    logic        d_oe;
    logic        chk_data;
    logic [15:0] data;
  } resp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  resp_t q0[$];
  resp_t q1[$];
  bit [7:0] mdl [2][LINES*16];

  mem_ctrl_if bus0 ();
  mem_ctrl_if bus1 ();

  mem_ctrl #(.MEM_LATENCY(LAT0)) u_dut0 (.CLK(clk), .RESET_N(rst_n), .bus(bus0));
  mem_ctrl #(.MEM_LATENCY(LAT1)) u_dut1 (.CLK(clk), .RESET_N(rst_n), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat(int l);
    return (l == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic busy(int l);
    return (l == 0) ? bus0.BUSY : bus1.BUSY;
  endfunction

  task automatic drive(int l, logic [1:0] c, logic [5:0] a, logic [15:0] d);
    if (l == 0) begin
      bus0.C2_IN = c; bus0.A2_IN = a; bus0.D2_IN = d;
    end else begin
      bus1.C2_IN = c; bus1.A2_IN = a; bus1.D2_IN = d;
    end
  endtask

  task automatic push(int l, resp_t r);
    if (l == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Monitor: pops one expectation per response cycle and compares it.
  task automatic monitor(int l, logic [1:0] c_out, logic c_oe, logic [15:0] d_out,
                         logic d_oe, logic bsy);
    resp_t r;
    int    depth;
    depth = (l == 0) ? q0.size() : q1.size();
    if (c_oe) begin
      if (depth == 0) begin
        check($sformatf("lane%0d_unexpected_response", l), c_oe, 1'b0);
        return;
      end
      if (l == 0) r = q0.pop_front();
      else        r = q1.pop_front();
      check($sformatf("lane%0d_resp_cycle", l), cyc, r.at);
      check($sformatf("lane%0d_resp_cmd", l), c_out, r.cmd);
      check($sformatf("lane%0d_resp_d2_oe", l), d_oe, r.d_oe);
      check($sformatf("lane%0d_resp_busy", l), bsy, 1'b1);
      if (r.chk_data) check($sformatf("lane%0d_resp_data", l), d_out, r.data);
    end else begin
      check($sformatf("lane%0d_quiet_c2_out", l), c_out, NOP);
      check($sformatf("lane%0d_quiet_d2_oe", l), d_oe, 1'b0);
    end
  endtask

  always @(negedge clk) monitor(0, bus0.C2_OUT, bus0.C2_OE, bus0.D2_OUT, bus0.D2_OE, bus0.BUSY);
  always @(negedge clk) monitor(1, bus1.C2_OUT, bus1.C2_OE, bus1.D2_OUT, bus1.D2_OE, bus1.BUSY);

  // Waits for IDLE; optionally throws random commands at the busy controller.
  task automatic wait_idle(int l, bit junk);
    int n = 0;
    while (busy(l) && n < 300) begin
      if (junk) drive(l, 2'($urandom_range(0, 3)), 6'($urandom), 16'($urandom));
      @(negedge clk);
      n++;
    end
    drive(l, NOP, 6'd0, 16'd0);
    if (n >= 300) check($sformatf("lane%0d_wait_idle_timeout", l), busy(l), 1'b0);
  endtask

  task automatic expect_read(int l, logic [5:0] a, int e0);
    resp_t r;
    int    base = int'(a) * 16;
    for (int k = 0; k < NB; k++) begin
      r.at       = e0 + lat(l) + k;
      r.cmd      = RESP;
      r.d_oe     = 1'b1;
      r.chk_data = 1'b1;
      r.data     = {mdl[l][base + 2*k + 1], mdl[l][base + 2*k]};
      push(l, r);
    end
  endtask

  task automatic issue_read(int l, logic [5:0] a, output int e0);
    wait_idle(l, 1'b1);
    drive(l, RD, a, 16'($urandom));
    @(negedge clk);
    e0 = cyc;
    drive(l, NOP, 6'($urandom), 16'($urandom));
    check($sformatf("lane%0d_read_accept", l), busy(l), 1'b1);
    expect_read(l, a, e0);
  endtask

  task automatic issue_write(int l, logic [5:0] a, logic [NB*16-1:0] line, output int e1);
    resp_t r;
    int    base = int'(a) * 16;
    wait_idle(l, 1'b1);
    for (int k = 0; k < NB; k++) begin
      if (k == 0) drive(l, WR, a, line[15:0]);
      else        drive(l, 2'($urandom_range(0, 3)), 6'($urandom), line[k*16 +: 16]);
      @(negedge clk);
      if (k == 0) check($sformatf("lane%0d_write_accept", l), busy(l), 1'b1);
    end
    e1 = cyc;
    drive(l, NOP, 6'd0, 16'd0);
    for (int j = 0; j < 16; j++) mdl[l][base + j] = line[j*8 +: 8];
    r.at       = e1 + lat(l);
    r.cmd      = RESP;
    r.d_oe     = 1'b0;
    r.chk_data = 1'b0;
    r.data     = '0;
    push(l, r);
  endtask

  // Holds READ on the bus from the first cycle after acceptance; the second
  // read may only land one edge after the controller has returned to IDLE.
  task automatic back_to_back(int l, logic [5:0] a1, logic [5:0] a2);
    int e0, e0b, n;
    issue_read(l, a1, e0);
    e0b = e0 + lat(l) + NB + 1;
    n = 0;
    while (cyc < e0b && n < 100) begin
      drive(l, RD, a2, 16'($urandom));
      @(negedge clk);
      n++;
    end
    drive(l, NOP, 6'd0, 16'd0);
    check($sformatf("lane%0d_b2b_accept", l), busy(l), 1'b1);
    expect_read(l, a2, e0b);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_busy0"},   bus0.BUSY,   1'b0);
    check({tag, "_c2_oe0"},  bus0.C2_OE,  1'b0);
    check({tag, "_d2_oe0"},  bus0.D2_OE,  1'b0);
    check({tag, "_c2_out0"}, bus0.C2_OUT, NOP);
    check({tag, "_d2_out0"}, bus0.D2_OUT, 16'h0);
    check({tag, "_busy1"},   bus1.BUSY,   1'b0);
    check({tag, "_c2_oe1"},  bus1.C2_OE,  1'b0);
    check({tag, "_d2_oe1"},  bus1.D2_OE,  1'b0);
    check({tag, "_c2_out1"}, bus1.C2_OUT, NOP);
    check({tag, "_d2_out1"}, bus1.D2_OUT, 16'h0);
  endtask

  task automatic random_ops(int l, int n_ops);
    int e;
    logic [5:0] a;
    for (int i = 0; i < n_ops; i++) begin
      a = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      if ($urandom_range(0, 1) == 1)
        issue_write(l, a, {$urandom, $urandom, $urandom, $urandom}, e);
      else
        issue_read(l, a, e);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e_a, e_b, e0;
    logic [NB*16-1:0] line3;

    for (int l = 0; l < 2; l++)
      for (int a = 0; a < LINES*16; a++) mdl[l][a] = 8'(a);
    drive(0, NOP, 6'd0, 16'd0);
    drive(1, NOP, 6'd0, 16'd0);

    #3;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // First rising edge after release must accept; line 5 returns 5150..5F5E.
    fork
      issue_read(0, 6'd5, e_a);
      issue_read(1, 6'd5, e_b);
    join

    // Write line 3 with an ascending pattern, then read it back.
    for (int k = 0; k < NB; k++) line3[k*16 +: 16] = 16'h0100 + 16'(k) * 16'h0202;
    fork
      begin issue_write(0, 6'd3, line3, e_a); issue_read(0, 6'd3, e_a); end
      begin issue_write(1, 6'd3, line3, e_b); issue_read(1, 6'd3, e_b); end
    join

    // RESPONSE / NOP codes in IDLE are ignored.
    wait_idle(0, 1'b0);
    wait_idle(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(0, (i % 2 == 0) ? RESP : NOP, 6'($urandom), 16'($urandom));
      drive(1, RESP, 6'($urandom), 16'($urandom));
      @(negedge clk);
      check("idle_cmd_busy0", bus0.BUSY, 1'b0);
      check("idle_cmd_c2_oe0", bus0.C2_OE, 1'b0);
      check("idle_cmd_d2_oe0", bus0.D2_OE, 1'b0);
      check("idle_cmd_busy1", bus1.BUSY, 1'b0);
      check("idle_cmd_c2_oe1", bus1.C2_OE, 1'b0);
    end
    drive(0, NOP, 6'd0, 16'd0);
    drive(1, NOP, 6'd0, 16'd0);

    // Commands during WAIT are ignored and BUSY holds for the whole request.
    issue_read(0, 6'd12, e0);
    drive(0, RD, 6'd40, 16'h1111);
    @(negedge clk);
    drive(0, WR, 6'd41, 16'h2222);
    @(negedge clk);
    drive(0, RD, 6'd42, 16'h3333);
    @(negedge clk);
    drive(0, NOP, 6'd0, 16'd0);
    while (cyc < e0 + LAT0 + NB - 1) begin
      check("busy_held_mid_request", bus0.BUSY, 1'b1);
      @(negedge clk);
    end

    // Earliest re-accept after the final response.
    fork
      back_to_back(1, 6'd9, 6'd10);
      back_to_back(0, 6'd11, 6'd3);
    join

    // Reset in the middle of a write: outputs drop at once, line stays intact.
    wait_idle(0, 1'b0);
    wait_idle(1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(0, (k == 0) ? WR : NOP, 6'd7, 16'hBEE0 + 16'(k));
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_in_write");
    drive(0, NOP, 6'd0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue_read(0, 6'd7, e0);

    // Reset in the middle of a read response: no further beats.
    wait_idle(0, 1'b0);
    issue_read(1, 6'd20, e0);
    while (cyc < e0 + LAT1 + 3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q1.delete();
    #1;
    check_reset_outputs("rst_in_read");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    fork
      random_ops(0, 30);
      random_ops(1, 30);
    join

    wait_idle(0, 1'b0);
    wait_idle(1, 1'b0);
    repeat (20) @(negedge clk);
    check("lane0_pending_responses", q0.size(), 0);
    check("lane1_pending_responses", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
